dut_op_driver: RTL and testbench
================================

// Module: dut_op_driver
// PURPOSE
//  Initiator side of the DUT op handshake (val_op/op_ack/op_commit/commit_ack). Accepts one
//  command from the host harness, launches it into the DUT controller, waits for commit,
//  captures the DUT result and its latency, acknowledges the commit, then returns a response.
//  One op in flight at a time; the block sits between the test harness and the DUT wrapper.
// PARAMETERS
//  DW          32   width of command operand and DUT result
//  CW          8    width of latency counter / resp_cycles
//  TIMEOUT_CYC 64   cycles allowed from val_op assertion to op_commit before abort (< 2**CW)
//  SNAP_CYCLE  3    WAIT-state cycle index at which the scan snapshot starts (SCAN_SNAPSHOT_EN only)
//  SNAP_LEN    4    cycles sen is held high per snapshot (SCAN_SNAPSHOT_EN only)
// PORTS
//  clk          in   1   clock
//  reset_n      in   1   asynchronous active-low reset
//  cmd_val      in   1   host command valid
//  cmd_rdy      out  1   driver can accept command (IDLE)
//  cmd_data     in   DW  operand forwarded to DUT
//  resp_val     out  1   response valid
//  resp_rdy     in   1   host accepts response
//  resp_data    out  DW  captured DUT result (0 on timeout)
//  resp_cycles  out  CW  cycles from val_op rise to op_commit seen, excluding sen cycles
//  resp_err     out  1   1 = op timed out
//  val_op       out  1   op request to DUT
//  op_ack       in   1   DUT accepted op (single-cycle pulse)
//  op_commit    in   1   DUT result ready (held until commit_ack)
//  commit_ack   out  1   single-cycle acknowledge of commit
//  dut_data_in  out  DW  operand register presented to DUT
//  dut_data_out in   DW  DUT result
//  sen          out  1   scan enable to DUT (freezes DUT FSM)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; all outputs 0 except cmd_rdy=1; counters 0.
//  FSM states: IDLE, REQ, WAIT, ACK, RESP.
//   IDLE: cmd_rdy=1. cmd_val&cmd_rdy -> latch cmd_data into dut_data_in, clear counter, -> REQ.
//   REQ:  val_op=1. op_ack sampled -> val_op low next cycle, -> WAIT. (val_op must drop on the
//         cycle after op_ack so the DUT does not relaunch from its idle state.)
//   WAIT: count cycles. op_commit -> capture dut_data_out and count into resp regs, -> ACK.
//   ACK:  commit_ack=1 for exactly one cycle, -> RESP. Never asserted outside ACK.
//   RESP: resp_val=1, resp_* stable until resp_rdy; resp_val&resp_rdy -> IDLE (cmd_rdy=1 next).
//  Latency counter: starts at 0 on REQ entry, +1 per cycle in REQ/WAIT, saturates at 2**CW-1;
//   does not increment while sen=1. Minimum against DUT: op_ack on cycle 1, commit ~10 cycles.
//  Timeout: counter reaching TIMEOUT_CYC in REQ or WAIT -> drop val_op, resp_err=1,
//   resp_data=0, resp_cycles=TIMEOUT_CYC, skip ACK, -> RESP.
//  Simultaneous: op_commit on the same cycle as timeout -> commit wins (no error).
//   op_ack and op_commit never sampled in the wrong state; stray pulses ignored.
//  cmd_val while not IDLE is ignored (cmd_rdy=0). Reset mid-op returns to IDLE without
//   commit_ack; DUT is expected to be reset alongside.
// CONFIGURATION
//  SCAN_SNAPSHOT_EN defined: in WAIT, when counter == SNAP_CYCLE, sen=1 for SNAP_LEN cycles,
//   once per op; latency and timeout counters frozen while sen=1; op_commit during sen is
//   still honoured after sen drops (sampled only when sen=0).
//  SCAN_SNAPSHOT_EN undefined: sen tied 0, SNAP_* parameters unused, no snapshot logic.
// STRUCTURE
//  Package dut_drv_pkg: state enum/localparams (IDLE..RESP), 3-bit state width, err codes.
//  Sub-module dut_drv_timer: CW-bit counter with clear, enable, freeze and saturate, plus
//   terminal-compare output; instantiated once for latency/timeout, once for snapshot length.
// TESTING
//  1 Basic op: cmd_data=0x0000_00A5, DUT ack at +1, commit at +10 -> commit_ack 1 cycle,
//    resp_data=DUT result, resp_cycles=10, resp_err=0.
//  2 Back-pressure: resp_rdy low 5 cycles -> resp_val/resp_data held stable; cmd_rdy stays 0.
//  3 Timeout: DUT never commits -> at 64 cycles val_op=0, resp_err=1, resp_data=0,
//    resp_cycles=64, commit_ack never asserted.
//  4 Race: op_commit arrives on cycle 64 -> resp_err=0, commit_ack issued, data captured.
//  5 Reset mid-WAIT: reset_n low 2 cycles -> all outputs 0, cmd_rdy=1, next op clean.
//  6 SCAN_SNAPSHOT_EN: sen high cycles 3..6 of WAIT, DUT commit delayed 4 -> resp_cycles=10.

Source files
------------

// File: rtl/dut_drv_pkg.sv
// Shared definitions for the DUT op driver slice.
// Contents:
//   STATE_W      width of the driver FSM state register
//   state_e      driver FSM states (IDLE, REQ, WAIT, ACK, RESP)
//   ERR_NONE     resp_err value for an op that committed
//   ERR_TIMEOUT  resp_err value for an op that was aborted by the watchdog
package dut_drv_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_ACK  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  localparam logic ERR_NONE    = 1'b0;
  localparam logic ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/dut_op_driver_if.sv
// Bundle of the host-side command/response handshake and the DUT-side
// op/commit handshake seen by dut_op_driver.
// Modports:
//   master  the driver: consumes host commands and DUT handshakes,
//           produces responses, val_op/commit_ack, operand and sen
//   slave   the surrounding harness/DUT wrapper (mirror of master)
// Signals:
//   cmd_val/cmd_rdy/cmd_data                         host command channel
//   resp_val/resp_rdy/resp_data/resp_cycles/resp_err host response channel
//   val_op/op_ack/op_commit/commit_ack               DUT op handshake
//   dut_data_in/dut_data_out                         DUT operand and result
//   sen                                              scan enable to the DUT
interface dut_op_driver_if #(
  parameter int DW = 32,
  parameter int CW = 8
) ();

  logic          cmd_val;
  logic          cmd_rdy;
  logic [DW-1:0] cmd_data;
  logic          resp_val;
  logic          resp_rdy;
  logic [DW-1:0] resp_data;
  logic [CW-1:0] resp_cycles;
  logic          resp_err;
  logic          val_op;
  logic          op_ack;
  logic          op_commit;
  logic          commit_ack;
  logic [DW-1:0] dut_data_in;
  logic [DW-1:0] dut_data_out;
  logic          sen;

  modport master (
    input  cmd_val, cmd_data, resp_rdy, op_ack, op_commit, dut_data_out,
    output cmd_rdy, resp_val, resp_data, resp_cycles, resp_err,
           val_op, commit_ack, dut_data_in, sen
  );

  modport slave (
    output cmd_val, cmd_data, resp_rdy, op_ack, op_commit, dut_data_out,
    input  cmd_rdy, resp_val, resp_data, resp_cycles, resp_err,
           val_op, commit_ack, dut_data_in, sen
  );

endinterface

// File: rtl/dut_drv_timer.sv
// Saturating up-counter with a terminal-value compare.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   clr           synchronous clear to 0 (wins over everything else)
//   en            count this cycle
//   freeze        hold the count even when en is high
//   count         current count (CW bits, sticks at all-ones)
//   term          high while count equals TERM
module dut_drv_timer #(
  parameter int CW   = 8,
  parameter int TERM = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
  input  logic          freeze,
  output logic [CW-1:0] count,
  output logic          term
);

  localparam logic [CW-1:0] TERM_VAL = CW'(TERM);
  localparam logic [CW-1:0] MAX_VAL  = '1;
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !freeze && (count_q != MAX_VAL)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign term  = (count_q == TERM_VAL);

endmodule

// File: rtl/dut_op_driver.sv
// Initiator side of the DUT op handshake. Takes one host command, launches it
// with val_op, waits for op_commit, captures the result and the latency,
// pulses commit_ack, then presents a response until the host takes it.
// A watchdog aborts the op with resp_err=1 after TIMEOUT_CYC cycles.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   bus           dut_op_driver_if.master (host command/response + DUT handshake)
// Optional feature (macro SCAN_SNAPSHOT_EN):
//   once per op, while in WAIT with the latency count at SNAP_CYCLE, sen is
//   raised for SNAP_LEN cycles; latency/timeout counting and commit sampling
//   pause while sen is high. Without the macro, sen is tied low.
module dut_op_driver
  import dut_drv_pkg::*;
#(
  parameter int DW          = 32,
  parameter int CW          = 8,
  parameter int TIMEOUT_CYC = 64
`ifdef SCAN_SNAPSHOT_EN
  ,
  parameter int SNAP_CYCLE  = 3,
  parameter int SNAP_LEN    = 4
`endif
) (
  input logic            clk,
  input logic            reset_n,
  dut_op_driver_if.master bus
);

  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYC);

  state_e        state_q, state_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic          val_op_q, val_op_d;
  logic          commit_ack_q, commit_ack_d;
  logic          resp_val_q, resp_val_d;
  logic          resp_err_q, resp_err_d;
  logic [DW-1:0] dut_data_in_q, dut_data_in_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic [CW-1:0] resp_cycles_q, resp_cycles_d;

  logic          lat_clr;
  logic          lat_en;
  logic [CW-1:0] lat_cnt;
  logic          lat_term;
  logic          sen_active;

  // Latency counter doubles as the timeout watchdog: both count the same
  // cycles and both pause during a scan snapshot.
  assign lat_en = (state_q == ST_REQ) || (state_q == ST_WAIT);

  dut_drv_timer #(
    .CW   (CW),
    .TERM (TIMEOUT_CYC)
  ) u_lat_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (lat_clr),
    .en      (lat_en),
    .freeze  (sen_active),
    .count   (lat_cnt),
    .term    (lat_term)
  );

  // Next-state and response capture. op_ack is only looked at in REQ and
  // op_commit only in WAIT (and only while sen is low), so stray pulses are
  // dropped. In WAIT, commit is checked before the watchdog so a commit that
  // lands on the timeout cycle still succeeds.
  always_comb begin
    state_d       = state_q;
    dut_data_in_d = dut_data_in_q;
    resp_data_d   = resp_data_q;
    resp_cycles_d = resp_cycles_q;
    resp_err_d    = resp_err_q;
    lat_clr       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_val && cmd_rdy_q) begin
          dut_data_in_d = bus.cmd_data;
          lat_clr       = 1'b1;
          state_d       = ST_REQ;
        end
      end
      ST_REQ: begin
        if (lat_term) begin
          resp_data_d   = '0;
          resp_cycles_d = TIMEOUT_VAL;
          resp_err_d    = ERR_TIMEOUT;
          state_d       = ST_RESP;
        end else if (bus.op_ack) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!sen_active) begin
          if (bus.op_commit) begin
            resp_data_d   = bus.dut_data_out;
            resp_cycles_d = lat_cnt;
            resp_err_d    = ERR_NONE;
            state_d       = ST_ACK;
          end else if (lat_term) begin
            resp_data_d   = '0;
            resp_cycles_d = TIMEOUT_VAL;
            resp_err_d    = ERR_TIMEOUT;
            state_d       = ST_RESP;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs are registered images of the next state, so they
    // change exactly on the state transition (val_op falls the cycle after
    // op_ack is sampled, commit_ack lives only for the one ACK cycle).
    cmd_rdy_d    = (state_d == ST_IDLE);
    val_op_d     = (state_d == ST_REQ);
    commit_ack_d = (state_d == ST_ACK);
    resp_val_d   = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cmd_rdy_q     <= 1'b1;
      val_op_q      <= 1'b0;
      commit_ack_q  <= 1'b0;
      resp_val_q    <= 1'b0;
      resp_err_q    <= 1'b0;
      dut_data_in_q <= '0;
      resp_data_q   <= '0;
      resp_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      cmd_rdy_q     <= cmd_rdy_d;
      val_op_q      <= val_op_d;
      commit_ack_q  <= commit_ack_d;
      resp_val_q    <= resp_val_d;
      resp_err_q    <= resp_err_d;
      dut_data_in_q <= dut_data_in_d;
      resp_data_q   <= resp_data_d;
      resp_cycles_q <= resp_cycles_d;
    end
  end

`ifdef SCAN_SNAPSHOT_EN
  localparam logic [CW-1:0] SNAP_AT = CW'(SNAP_CYCLE);

  logic          sen_q, sen_d;
  logic [CW-1:0] snap_cnt;
  logic          snap_term;

  // Counts sen-high cycles for the current op. It is cleared on op launch and
  // stays non-zero after the snapshot, which is what limits it to once per op.
  dut_drv_timer #(
    .CW   (CW),
    .TERM (SNAP_LEN - 1)
  ) u_snap_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (lat_clr),
    .en      (sen_q),
    .freeze  (1'b0),
    .count   (snap_cnt),
    .term    (snap_term)
  );

  // Start only if the op is staying in WAIT; a commit sampled on the start
  // cycle ends the op and must not leave sen hanging.
  always_comb begin
    sen_d = sen_q;
    if (lat_clr) begin
      sen_d = 1'b0;
    end else if (sen_q) begin
      if (snap_term) begin
        sen_d = 1'b0;
      end
    end else if ((state_q == ST_WAIT) && (state_d == ST_WAIT) &&
                 (snap_cnt == '0) && (lat_cnt == SNAP_AT)) begin
      sen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sen_q <= 1'b0;
    end else begin
      sen_q <= sen_d;
    end
  end

  assign sen_active = sen_q;
`else
  assign sen_active = 1'b0;
`endif

  assign bus.cmd_rdy     = cmd_rdy_q;
  assign bus.val_op      = val_op_q;
  assign bus.commit_ack  = commit_ack_q;
  assign bus.resp_val    = resp_val_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_cycles = resp_cycles_q;
  assign bus.dut_data_in = dut_data_in_q;
  assign bus.sen         = sen_active;

endmodule

// File: tb/tb_dut_op_driver.sv
// Self-checking bench for dut_op_driver.
// Each op is described by: ack cycle, commit cycle (-1 = never), DUT result
// and host back-pressure. Cycle 0 is the first cycle val_op is high. From
// that description the bench works out when the op ends and how, then a
// compare process checks every output on every cycle of the op. Directed
// literal checks after each op pin the model to hand-computed numbers.
module tb_dut_op_driver;

  localparam int DW         = 32;
  localparam int CW         = 8;
  localparam int T          = 64;
  localparam int SNAP_CYCLE = 3;
  localparam int SNAP_LEN   = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  dut_op_driver_if #(.DW(DW), .CW(CW)) bus ();

  dut_op_driver #(.DW(DW), .CW(CW), .TIMEOUT_CYC(T)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Current op description and derived expectations
  logic [DW-1:0] op_cmd, op_res;
  int  op_a, op_c, op_bp;
  bit  snap_on = 1'b0;
  int  exp_end, exp_ack_k;
  bit  exp_to;
  bit  model_active = 1'b0;
  int  k = 0;

  // Response captured at the host handshake
  logic [DW-1:0] got_data;
  int  got_cycles;
  bit  got_err;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Snapshot window: raised the cycle after the count reads SNAP_CYCLE, and
  // since the count equals the cycle index before any freeze, that is fixed.
  function automatic bit sen_at(input int kk);
    return snap_on && (kk >= SNAP_CYCLE + 1) && (kk <= SNAP_CYCLE + SNAP_LEN);
  endfunction

  // Latency count visible in cycle kk: cycles before kk that were not frozen.
  function automatic int count_at(input int kk);
    int c = 0;
    for (int j = 0; j < kk; j++) if (!sen_at(j)) c++;
    return c;
  endfunction

  // Decide how the op ends: ack moves it to waiting, a commit seen while
  // waiting ends it, reaching T counted cycles first aborts it. In the
  // waiting phase a commit on the T cycle wins over the abort.
  function automatic void resolve();
    snap_on = 1'b0;
`ifdef SCAN_SNAPSHOT_EN
    snap_on = (op_a < SNAP_CYCLE) && ((op_c < 0) || (op_c > SNAP_CYCLE));
`endif
    exp_to = 1'b0; exp_ack_k = -1; exp_end = -1;
    for (int kk = 0; kk < 1000 && exp_end < 0; kk++) begin
      if (exp_ack_k < 0) begin
        if (count_at(kk) == T) begin exp_to = 1'b1; exp_end = kk; end
        else if (kk == op_a) exp_ack_k = kk;
      end else if (!sen_at(kk)) begin
        if (op_c >= 0 && kk >= op_c) exp_end = kk;
        else if (count_at(kk) == T) begin exp_to = 1'b1; exp_end = kk; end
      end
    end
  endfunction

  // Per-cycle compare against the op timeline
  always @(negedge clk) begin
    if (model_active) begin
      int rs, hs, vlast;
      rs    = exp_end + (exp_to ? 1 : 2);
      hs    = rs + op_bp;
      vlast = (exp_ack_k >= 0) ? exp_ack_k : exp_end;
      checkOutput($sformatf("val_op@%0d", k), bus.val_op, k <= vlast);
      checkOutput($sformatf("commit_ack@%0d", k), bus.commit_ack, !exp_to && (k == exp_end + 1));
      checkOutput($sformatf("resp_val@%0d", k), bus.resp_val, (k >= rs) && (k <= hs));
      checkOutput($sformatf("cmd_rdy@%0d", k), bus.cmd_rdy, k > hs);
      checkOutput($sformatf("sen@%0d", k), bus.sen, sen_at(k));
      checkOutput($sformatf("dut_data_in@%0d", k), bus.dut_data_in, op_cmd);
      if ((k >= rs) && (k <= hs)) begin
        checkOutput($sformatf("resp_data@%0d", k), bus.resp_data, exp_to ? 0 : op_res);
        checkOutput($sformatf("resp_cycles@%0d", k), bus.resp_cycles, exp_to ? T : count_at(exp_end));
        checkOutput($sformatf("resp_err@%0d", k), bus.resp_err, exp_to);
      end
    end
  end

  // Runs one op: host command, DUT-side ack/commit behaviour, host
  // response acceptance after bp cycles of resp_val.
  task automatic applyStimulus(input logic [DW-1:0] cmd, input int a, input int c,
                               input logic [DW-1:0] res, input int bp);
    int  seen = 0;
    int  hs_k = -1;
    bit  pend = 1'b0;
    bit  ack_seen = 1'b0;
    bit  done = 1'b0;
    op_cmd = cmd; op_a = a; op_c = c; op_res = res; op_bp = bp;
    resolve();
    bus.cmd_val  = 1'b1;
    bus.cmd_data = cmd;
    @(posedge clk); #1;
    bus.cmd_val  = 1'b0;
    bus.cmd_data = ~cmd;
    k = 0;
    model_active = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      if (ack_seen) pend = 1'b0;
      if (k == c) pend = 1'b1;
      bus.op_ack       = (k == a);
      bus.op_commit    = pend;
      bus.dut_data_out = pend ? res : ~res;
      bus.resp_rdy     = (seen >= bp);
      @(negedge clk);
      if (bus.commit_ack) ack_seen = 1'b1;
      if (bus.resp_val && bus.resp_rdy) begin
        hs_k       = k;
        got_data   = bus.resp_data;
        got_cycles = int'(bus.resp_cycles);
        got_err    = bus.resp_err;
      end
      if (bus.resp_val) seen++;
      if (hs_k >= 0 && k == hs_k + 1) done = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    #1;
    model_active     = 1'b0;
    bus.op_ack       = 1'b0;
    bus.op_commit    = 1'b0;
    bus.resp_rdy     = 1'b0;
    bus.dut_data_out = '0;
    if (!done) checkOutput("op_completes", 0, 1);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_cmd_rdy"}, bus.cmd_rdy, 1);
    checkOutput({tag, "_val_op"}, bus.val_op, 0);
    checkOutput({tag, "_commit_ack"}, bus.commit_ack, 0);
    checkOutput({tag, "_resp_val"}, bus.resp_val, 0);
    checkOutput({tag, "_resp_data"}, bus.resp_data, 0);
    checkOutput({tag, "_resp_cycles"}, bus.resp_cycles, 0);
    checkOutput({tag, "_resp_err"}, bus.resp_err, 0);
    checkOutput({tag, "_dut_data_in"}, bus.dut_data_in, 0);
    checkOutput({tag, "_sen"}, bus.sen, 0);
  endtask

  initial begin
    bus.cmd_val = 1'b0; bus.cmd_data = '0; bus.resp_rdy = 1'b0;
    bus.op_ack = 1'b0; bus.op_commit = 1'b0; bus.dut_data_out = '0;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic op");
    applyStimulus(32'h0000_00A5, 1, 10, 32'h0000_014A, 0);
    checkOutput("t1_cycles", got_cycles, 10);
    checkOutput("t1_data", got_data, 32'h0000_014A);
    checkOutput("t1_err", got_err, 0);

    $display("[TB] back-pressure");
    applyStimulus(32'h0000_1234, 1, 12, 32'h0BAD_F00D, 5);
    checkOutput("t2_cycles", got_cycles, 12);
    checkOutput("t2_data", got_data, 32'h0BAD_F00D);

    $display("[TB] timeout in WAIT");
    applyStimulus(32'h5555_0003, 1, -1, 32'h1111_1111, 1);
    checkOutput("t3_err", got_err, 1);
    checkOutput("t3_data", got_data, 0);
    checkOutput("t3_cycles", got_cycles, 64);

    $display("[TB] commit on timeout cycle");
    applyStimulus(32'h6666_0004, 2, 64, 32'h4444_4444, 0);
    checkOutput("t4_err", got_err, 0);
    checkOutput("t4_cycles", got_cycles, 64);
    checkOutput("t4_data", got_data, 32'h4444_4444);

    $display("[TB] commit one cycle late");
    applyStimulus(32'h6666_0005, 1, 65, 32'h4545_4545, 0);
    checkOutput("t4b_err", got_err, 1);
    checkOutput("t4b_data", got_data, 0);

    $display("[TB] timeout in REQ");
    applyStimulus(32'h7777_0006, 1000, -1, 32'h2222_2222, 0);
    checkOutput("t5_err", got_err, 1);
    checkOutput("t5_cycles", got_cycles, 64);

    $display("[TB] ack on first cycle");
    applyStimulus(32'h0000_0007, 0, 3, 32'h0000_0077, 2);
    checkOutput("t6_cycles", got_cycles, 3);
    checkOutput("t6_data", got_data, 32'h0000_0077);

    $display("[TB] stray pulses while idle");
    bus.op_ack = 1'b1; bus.op_commit = 1'b1; bus.resp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stray_cmd_rdy", bus.cmd_rdy, 1);
      checkOutput("stray_val_op", bus.val_op, 0);
      checkOutput("stray_commit_ack", bus.commit_ack, 0);
      checkOutput("stray_resp_val", bus.resp_val, 0);
    end
    bus.op_ack = 1'b0; bus.op_commit = 1'b0; bus.resp_rdy = 1'b0;

    $display("[TB] reset mid-WAIT");
    bus.cmd_val = 1'b1; bus.cmd_data = 32'hCAFE_0001;
    @(posedge clk); #1;
    bus.cmd_val = 1'b0;
    @(posedge clk); #1;
    bus.op_ack = 1'b1;
    @(posedge clk); #1;
    bus.op_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midop_cmd_rdy", bus.cmd_rdy, 0);
    checkOutput("midop_dut_data_in", bus.dut_data_in, 32'hCAFE_0001);
    reset_n = 1'b0;
    #1;
    checkIdle("async_rst");
    @(negedge clk);
    @(negedge clk);
    checkIdle("held_rst");
    reset_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h0000_0ABC, 1, 11, 32'h0000_5678, 0);
    checkOutput("t7_cycles", got_cycles, 11);
    checkOutput("t7_data", got_data, 32'h0000_5678);

`ifdef SCAN_SNAPSHOT_EN
    $display("[TB] scan snapshot");
    applyStimulus(32'h0000_0099, 1, 14, 32'h0000_9999, 0);
    checkOutput("t8_cycles", got_cycles, 10);
    checkOutput("t8_err", got_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
